// File: rtl/constants_pkg.sv
// Shared constants and types for the instruction cache.
// ICLLEN        : cache line width in bits (four 32-bit words)
// ICACHE_LINES  : default number of direct-mapped lines
// ICACHE_IDX_W  : index width for the default line count
// ICACHE_TAG_W  : tag width for a 32-bit byte address
// icache_state_t: miss-handling FSM states
package constants_pkg;

  localparam int unsigned ICLLEN       = 128;
  localparam int unsigned ICACHE_LINES = 4;
  localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned ICACHE_TAG_W = 32 - $clog2(ICLLEN / 8) - ICACHE_IDX_W;

  typedef enum logic [0:0] {
    IDLE,
    MISS
  } icache_state_t;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave : the cache's view (takes fetch requests and line fills, drives responses and ldp/ldAddr)
// master: the environment's view (fetch stage plus line server)
interface icache_direct_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ICLLEN = constants_pkg::ICLLEN
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              resp_valid;
  logic [31:0]       resp_instr;
  logic              stall;
  logic              ldp;
  logic [ADDR_W-1:0] ldAddr;
  logic              ldr;
  logic [ICLLEN-1:0] ldData;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  modport slave (
    input  req_valid, req_addr, flush, ldr, ldData,
    output resp_valid, resp_instr, stall, ldp, ldAddr, hit_count, miss_count
  );

  modport master (
    output req_valid, req_addr, flush, ldr, ldData,
    input  resp_valid, resp_instr, stall, ldp, ldAddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_direct_array.sv
// Data/tag/valid storage for the direct-mapped instruction cache.
// clk, rst  : clock, asynchronous active-high reset (clears valid bits only)
// rd_idx_i  : combinational read index -> rd_valid_o, rd_tag_o, rd_data_o
// wr_en_i   : write wr_tag_i/wr_data_i at wr_idx_i and set its valid bit
// flush_i   : clear every valid bit except the one being written this edge
module icache_array #(
  parameter int unsigned NLINES = 4,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned TAG_W  = 26,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_data_i,
  input  logic              flush_i
);
  logic [LINE_W-1:0] data_q [NLINES];
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [NLINES-1:0] valid_q;

  // A fill landing on the same edge as a flush keeps its own line valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NLINES; i++) begin
        if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
          valid_q[i] <= 1'b1;
        end else if (flush_i) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_idx_i] <= wr_data_i;
      tag_q[wr_idx_i]  <= wr_tag_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache between fetch and the line server.
// clk, rst : clock, asynchronous active-high reset
// bus      : fetch request/response, flush, line-load handshake (ldp/ldAddr -> ldr/ldData),
//            saturating hit/miss counters
// A hit answers in the same cycle; a miss stalls, loads the whole line, then replays the lookup.
module icache_direct
  import constants_pkg::*;
#(
  parameter int unsigned NLINES = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ICLLEN = constants_pkg::ICLLEN
) (
  input  logic             clk,
  input  logic             rst,
  icache_direct_if.slave   bus
);
  localparam int unsigned OFF_W  = $clog2(ICLLEN / 8);
  localparam int unsigned WSEL_W = $clog2(ICLLEN / 32);
  localparam int unsigned IDX_W  = $clog2(NLINES);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;

  icache_state_t     state_q, state_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  req_idx, miss_idx;
  logic [TAG_W-1:0]  req_tag, miss_tag, rd_tag;
  logic [WSEL_W-1:0] req_wsel;
  logic [ICLLEN-1:0] rd_data;
  logic              rd_valid;
  logic              hit;
  logic              fill;

  assign req_idx  = bus.req_addr[OFF_W +: IDX_W];
  assign req_tag  = bus.req_addr[ADDR_W-1 -: TAG_W];
  assign req_wsel = bus.req_addr[2 +: WSEL_W];
  assign miss_idx = miss_addr_q[OFF_W +: IDX_W];
  assign miss_tag = miss_addr_q[ADDR_W-1 -: TAG_W];

  // ldr outside MISS is a stray pulse and must not write.
  assign fill = (state_q == MISS) && bus.ldr;
  assign hit  = bus.req_valid && (state_q == IDLE) && rd_valid && (rd_tag == req_tag);

  icache_array #(
    .NLINES (NLINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .LINE_W (ICLLEN)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (fill),
    .wr_idx_i   (miss_idx),
    .wr_tag_i   (miss_tag),
    .wr_data_i  (bus.ldData),
    .flush_i    (bus.flush)
  );

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (hit) begin
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            miss_addr_d = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
            state_d = MISS;
          end
        end
      end
      MISS: begin
        if (bus.ldr) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign bus.resp_valid = hit;
  assign bus.resp_instr = hit ? rd_data[32*req_wsel +: 32] : 32'd0;
  assign bus.stall      = bus.req_valid && !hit;
  // Moore output: drops the cycle after ldr so the server cannot re-trigger.
  assign bus.ldp        = (state_q == MISS);
  assign bus.ldAddr     = miss_addr_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_direct_if #(.ADDR_W(32), .ICLLEN(128)) bus ();

  icache_direct #(
    .NLINES (4),
    .ADDR_W (32),
    .ICLLEN (128)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int exp_h  = 0;
  int exp_m  = 0;
  int fills  = 0;
  bit mem_en = 1'b1;
  bit mem_s;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    bit          sync;
  } vec_t;
  vec_t vecs [10];

  function automatic logic [31:0] instr_at(input logic [31:0] b);
    return 32'h0000_8093 | (((b >> 2) + 32'd1) << 20);
  endfunction

  function automatic logic [127:0] line_for(input logic [31:0] a);
    return {instr_at(a + 32'd12), instr_at(a + 32'd8), instr_at(a + 32'd4), instr_at(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One-cycle line server: ldr follows the first cycle ldp is seen high.
  always begin
    @(posedge clk);
    mem_s = bus.ldp;
    #1;
    if (mem_en) begin
      if (bus.ldr) begin
        bus.ldr = 1'b0;
      end else if (mem_s) begin
        bus.ldr    = 1'b1;
        bus.ldData = line_for(bus.ldAddr);
        fills++;
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input bit miss, input string nm);
    int st;
    bit got;
    st  = 0;
    got = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    exp_q.push_back(instr_at(a));
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        got = 1'b1;
        chk({nm, " instr"}, bus.resp_instr, exp_q.pop_front());
      end else begin
        st++;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL %s timeout: no resp_valid within 20 cycles", nm);
      void'(exp_q.pop_front());
    end
    chk({nm, " stall cycles"}, 32'(st), miss ? 32'd3 : 32'd0);
    if (miss) exp_m++;
    exp_h++;
  endtask

  task automatic chk_counts(input string nm);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk({nm, " hit_count"}, bus.hit_count, 32'(exp_h));
    chk({nm, " miss_count"}, bus.miss_count, 32'(exp_m));
    chk({nm, " stall idle"}, 32'(bus.stall), 32'd0);
  endtask

  initial begin
    int f0;
    vecs[0] = '{32'h04, 1'b0, 1'b0};
    vecs[1] = '{32'h08, 1'b0, 1'b0};
    vecs[2] = '{32'h0C, 1'b0, 1'b1};
    vecs[3] = '{32'h40, 1'b1, 1'b0};
    vecs[4] = '{32'h00, 1'b1, 1'b1};
    vecs[5] = '{32'h10, 1'b1, 1'b0};
    vecs[6] = '{32'h18, 1'b0, 1'b0};
    vecs[7] = '{32'h44, 1'b1, 1'b0};
    vecs[8] = '{32'h04, 1'b1, 1'b0};
    vecs[9] = '{32'h08, 1'b0, 1'b1};

    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    bus.flush     = 1'b0;
    bus.ldr       = 1'b0;
    bus.ldData    = '0;
    @(negedge clk);
    chk("reset stall=req_valid", 32'(bus.stall), 32'd1);
    chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset ldp", 32'(bus.ldp), 32'd0);
    chk("reset ldAddr", bus.ldAddr, 32'd0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle stall", 32'(bus.stall), 32'd0);
    chk("reset hit_count", bus.hit_count, 32'd0);
    chk("reset miss_count", bus.miss_count, 32'd0);

    // Cold miss with cycle-by-cycle latency.
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    exp_q.push_back(instr_at(32'h0));
    @(negedge clk);
    chk("cold c0 stall", 32'(bus.stall), 32'd1);
    chk("cold c0 ldp", 32'(bus.ldp), 32'd0);
    @(negedge clk);
    chk("cold c1 ldp", 32'(bus.ldp), 32'd1);
    chk("cold c1 ldAddr", bus.ldAddr, 32'h0);
    @(negedge clk);
    chk("cold c2 ldr", 32'(bus.ldr), 32'd1);
    chk("cold c2 resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk("cold c3 resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("cold c3 instr", bus.resp_instr, exp_q.pop_front());
    chk("cold c3 miss_count", bus.miss_count, 32'd1);
    exp_m++;
    exp_h++;

    // Same-line hits, conflicts, more fills.
    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].addr, vecs[i].miss, $sformatf("vec%0d@%h", i, vecs[i].addr));
      if (vecs[i].sync) chk_counts($sformatf("vec%0d", i));
    end

    // Flush, then a previously-filled line must miss again.
    @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    f0 = fills;
    do_req(32'h00, 1'b1, "after flush");
    chk("after flush line load", 32'(fills - f0), 32'd1);
    chk_counts("flush");

    // req_addr changes during MISS: fill completes for 0x10, then 0x20 misses.
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    @(negedge clk);
    chk("midmiss c0 stall", 32'(bus.stall), 32'd1);
    @(posedge clk);
    #1 bus.req_addr = 32'h20;
    exp_q.push_back(instr_at(32'h20));
    @(negedge clk);
    chk("midmiss c1 ldAddr", bus.ldAddr, 32'h10);
    @(negedge clk);
    @(negedge clk);
    chk("midmiss c3 resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midmiss c3 stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    chk("midmiss c4 ldAddr", bus.ldAddr, 32'h20);
    @(negedge clk);
    @(negedge clk);
    chk("midmiss c6 resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("midmiss c6 instr", bus.resp_instr, exp_q.pop_front());
    exp_m += 2;
    exp_h++;
    do_req(32'h10, 1'b0, "midmiss 0x10 filled");
    chk_counts("midmiss");

    // Flush coinciding with the fill: filled line survives, others cleared.
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h30;
    exp_q.push_back(instr_at(32'h30));
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("flush+fill c2 ldr", 32'(bus.ldr), 32'd1);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush+fill c3 resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("flush+fill c3 instr", bus.resp_instr, exp_q.pop_front());
    exp_m++;
    exp_h++;
    do_req(32'h34, 1'b0, "flush+fill kept");
    do_req(32'h14, 1'b1, "flush+fill cleared");
    chk_counts("flush+fill");

    // Reset in the middle of a miss, then a stray ldr.
    mem_en = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h70;
    @(posedge clk);
    #1;
    chk("rstmiss c1 ldp", 32'(bus.ldp), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmiss ldp", 32'(bus.ldp), 32'd0);
    chk("rstmiss ldAddr", bus.ldAddr, 32'd0);
    chk("rstmiss stall", 32'(bus.stall), 32'd1);
    chk("rstmiss resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rstmiss miss_count", bus.miss_count, 32'd0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.ldr       = 1'b1;
    bus.ldData    = line_for(32'h70);
    @(posedge clk);
    #1 bus.ldr = 1'b0;
    @(negedge clk);
    chk("stray ldr ldp", 32'(bus.ldp), 32'd0);
    mem_en = 1'b1;
    exp_h  = 0;
    exp_m  = 0;
    do_req(32'h70, 1'b1, "after reset 0x70");
    do_req(32'h00, 1'b1, "after reset 0x00");
    chk_counts("after reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
